// File: rtl/fwd_hazard_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fwd_hazard_if : pipeline-side bundle for the forwarding / hazard unit
// Revision 1.0
// ----------------------------------------------------------------------------
interface fwd_hazard_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int AW      = 5,
    parameter int CNT_W   = 16
);
    localparam int SW = $clog2(NUM_STG + 1);

    logic [NUM_SRC*AW-1:0] id_rs;
    logic [NUM_SRC-1:0]    id_rs_used;
    logic [NUM_SRC*AW-1:0] ex_rs;
    logic [AW-1:0]         ex_rd;
    logic                  ex_reg_wr;
    logic                  ex_is_load;
    logic [NUM_STG*AW-1:0] stg_rd;
    logic [NUM_STG-1:0]    stg_reg_wr;
    logic                  mem_busy;
    logic                  flush;
    logic [NUM_SRC*SW-1:0] fwd_sel;
    logic                  stall;
    logic                  bubble;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs, id_rs_used, ex_rs, ex_rd, ex_reg_wr, ex_is_load,
               stg_rd, stg_reg_wr, mem_busy, flush,
        input  fwd_sel, stall, bubble, stall_cycles
    );

    modport slave (
        input  id_rs, id_rs_used, ex_rs, ex_rd, ex_reg_wr, ex_is_load,
               stg_rd, stg_reg_wr, mem_busy, flush,
        output fwd_sel, stall, bubble, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fwd_hazard_unit : EX operand forwarding select plus load-use interlock
// Revision 1.0
// ----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int NUM_SRC  = 2,
    parameter int NUM_STG  = 2,
    parameter int LOAD_LAT = 1,
    parameter int AW       = 5,
    parameter int CNT_W    = 16
) (
    input  wire          clk,
    input  wire          rst_n,
    fwd_hazard_if.slave  bus
);
    localparam int SW = $clog2(NUM_STG + 1);
    localparam int CW = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0] C_CNT_INIT = CW'(LOAD_LAT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic             w_hazard;
    logic             w_stall;

    // Scan oldest to youngest so the youngest matching stage is written last.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [SW-1:0] w_sel;
        always_comb begin
            w_sel = '0;
            for (int k = NUM_STG - 1; k >= 0; k--) begin
                if (bus.stg_reg_wr[k] &&
                    (bus.stg_rd[k*AW +: AW] != '0) &&
                    (bus.stg_rd[k*AW +: AW] == bus.ex_rs[i*AW +: AW])) begin
                    w_sel = SW'(k + 1);
                end
            end
        end
        assign bus.fwd_sel[i*SW +: SW] = w_sel;
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_rs_used[i] && (bus.id_rs[i*AW +: AW] == bus.ex_rd)) begin
                w_hazard = 1'b1;
            end
        end
        w_hazard = w_hazard && bus.ex_is_load && bus.ex_reg_wr && (bus.ex_rd != '0);
    end

    // Gated by rst_n so a held reset never leaks a stall from live hazard inputs.
    always_comb begin
        w_stall = 1'b0;
        if (rst_n && !bus.flush) begin
            w_stall = (state_q == S_WAIT) || w_hazard;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.bubble       = w_stall;
    assign bus.stall_cycles = stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (w_stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end

            if (bus.flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (w_hazard && (LOAD_LAT > 1)) begin
                            state_q <= S_WAIT;
                            cnt_q   <= C_CNT_INIT;
                        end
                    end
                    S_WAIT: begin
                        if (!bus.mem_busy) begin
                            cnt_q <= cnt_q - CW'(1);
                            if (cnt_q == CW'(1)) begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fwd_hazard_unit : directed bench, default config (A) and 4-stage/LAT3 (B)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_fwd_hazard_unit;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fwd_hazard_if #(.NUM_SRC(2), .NUM_STG(2), .AW(5), .CNT_W(16)) bus_a ();
    fwd_hazard_if #(.NUM_SRC(2), .NUM_STG(4), .AW(5), .CNT_W(4))  bus_b ();

    fwd_hazard_unit #(.NUM_SRC(2), .NUM_STG(2), .LOAD_LAT(1), .AW(5), .CNT_W(16)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    fwd_hazard_unit #(.NUM_SRC(2), .NUM_STG(4), .LOAD_LAT(3), .AW(5), .CNT_W(4)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        bus_a.id_rs = '0; bus_a.id_rs_used = '0; bus_a.ex_rs = '0; bus_a.ex_rd = '0;
        bus_a.ex_reg_wr = 1'b0; bus_a.ex_is_load = 1'b0; bus_a.stg_rd = '0;
        bus_a.stg_reg_wr = '0; bus_a.mem_busy = 1'b0; bus_a.flush = 1'b0;
    endtask

    task automatic clr_b();
        bus_b.id_rs = '0; bus_b.id_rs_used = '0; bus_b.ex_rs = '0; bus_b.ex_rd = '0;
        bus_b.ex_reg_wr = 1'b0; bus_b.ex_is_load = 1'b0; bus_b.stg_rd = '0;
        bus_b.stg_reg_wr = '0; bus_b.mem_busy = 1'b0; bus_b.flush = 1'b0;
    endtask

    // Load in EX writing r7, ID operand 1 reads r7.
    task automatic load_b();
        bus_b.ex_is_load = 1'b1; bus_b.ex_reg_wr = 1'b1; bus_b.ex_rd = 5'd7;
        bus_b.id_rs = {5'd7, 5'd2}; bus_b.id_rs_used = 2'b10;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        clr_a();
        clr_b();
        bus_a.ex_is_load = 1'b1; bus_a.ex_reg_wr = 1'b1; bus_a.ex_rd = 5'd7;
        bus_a.id_rs = {5'd7, 5'd0}; bus_a.id_rs_used = 2'b10;
        #12;
        chk("rst_a_stall", 32'(bus_a.stall), 32'd0);
        chk("rst_a_bubble", 32'(bus_a.bubble), 32'd0);
        chk("rst_a_cnt", 32'(bus_a.stall_cycles), 32'd0);
        chk("rst_b_cnt", 32'(bus_b.stall_cycles), 32'd0);
        clr_a();
        #6;
        rst_n = 1'b1;
        tick();

        // Forwarding, config A
        bus_a.ex_rs = {5'd0, 5'd5}; bus_a.stg_rd = {5'd5, 5'd5}; bus_a.stg_reg_wr = 2'b11;
        #2 chk("fwd_a_youngest", 32'(bus_a.fwd_sel), 32'h1);
        bus_a.stg_reg_wr = 2'b10;
        #2 chk("fwd_a_older", 32'(bus_a.fwd_sel), 32'h2);
        bus_a.ex_rs = '0; bus_a.stg_rd = '0; bus_a.stg_reg_wr = 2'b11;
        #2 chk("fwd_a_x0", 32'(bus_a.fwd_sel), 32'h0);
        bus_a.ex_rs = {5'd5, 5'd3}; bus_a.stg_rd = {5'd3, 5'd5};
        #2 chk("fwd_a_two_ops", 32'(bus_a.fwd_sel), 32'h6);
        clr_a();

        // Forwarding, config B (3-bit select per operand)
        bus_b.ex_rs = {5'd9, 5'd0}; bus_b.stg_rd = {5'd9, 5'd3, 5'd2, 5'd1};
        bus_b.stg_reg_wr = 4'b1111;
        #2 chk("fwd_b_stage3", 32'(bus_b.fwd_sel), 32'd32);
        bus_b.ex_rs = {5'd7, 5'd12}; bus_b.stg_rd = {5'd12, 5'd12, 5'd12, 5'd7};
        bus_b.stg_reg_wr = 4'b1101;
        #2 chk("fwd_b_stage2_prio", 32'(bus_b.fwd_sel), 32'd11);
        clr_b();

        // Load-use, LOAD_LAT=1
        tick();
        bus_a.ex_is_load = 1'b1; bus_a.ex_reg_wr = 1'b1; bus_a.ex_rd = 5'd7;
        bus_a.id_rs = {5'd7, 5'd2}; bus_a.id_rs_used = 2'b10;
        #2 chk("lu_a_stall", 32'(bus_a.stall), 32'd1);
        chk("lu_a_bubble", 32'(bus_a.bubble), 32'd1);
        chk("lu_a_cnt0", 32'(bus_a.stall_cycles), 32'd0);
        tick();
        bus_a.ex_is_load = 1'b0;
        #2 chk("lu_a_release", 32'(bus_a.stall), 32'd0);
        chk("lu_a_cnt1", 32'(bus_a.stall_cycles), 32'd1);
        tick();
        bus_a.ex_is_load = 1'b1; bus_a.id_rs_used = 2'b01;
        #2 chk("lu_a_unused", 32'(bus_a.stall), 32'd0);
        bus_a.ex_rd = 5'd0; bus_a.id_rs = '0; bus_a.id_rs_used = 2'b11;
        #2 chk("lu_a_x0", 32'(bus_a.stall), 32'd0);
        tick();
        chk("lu_a_cnt_hold", 32'(bus_a.stall_cycles), 32'd1);
        clr_a();

        // LOAD_LAT=3 with two busy cycles in WAIT -> five stall cycles
        load_b();
        #2 chk("wb_c1", 32'(bus_b.stall), 32'd1);
        tick();
        clr_b(); bus_b.mem_busy = 1'b1;
        #2 chk("wb_c2_busy", 32'(bus_b.stall), 32'd1);
        tick();
        #2 chk("wb_c3_busy", 32'(bus_b.stall), 32'd1);
        tick();
        bus_b.mem_busy = 1'b0;
        #2 chk("wb_c4", 32'(bus_b.stall), 32'd1);
        tick();
        #2 chk("wb_c5", 32'(bus_b.stall), 32'd1);
        tick();
        #2 chk("wb_c6_done", 32'(bus_b.stall), 32'd0);
        chk("wb_cnt5", 32'(bus_b.stall_cycles), 32'd5);

        // Flush on the second stall cycle
        tick();
        load_b();
        #2 chk("fl_c1", 32'(bus_b.stall), 32'd1);
        tick();
        clr_b(); bus_b.flush = 1'b1;
        #2 chk("fl_c2_flushed", 32'(bus_b.stall), 32'd0);
        tick();
        bus_b.flush = 1'b0;
        #2 chk("fl_c3_idle", 32'(bus_b.stall), 32'd0);
        chk("fl_cnt6", 32'(bus_b.stall_cycles), 32'd6);

        // Async reset in the middle of WAIT
        tick();
        load_b();
        tick();
        clr_b();
        #2 chk("ar_in_wait", 32'(bus_b.stall), 32'd1);
        chk("ar_cnt7", 32'(bus_b.stall_cycles), 32'd7);
        rst_n = 1'b0;
        #1 chk("ar_stall_now", 32'(bus_b.stall), 32'd0);
        chk("ar_cnt_now", 32'(bus_b.stall_cycles), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        #2 chk("ar_idle_after", 32'(bus_b.stall), 32'd0);

        // Saturation: 20 back-to-back stall cycles into a 4-bit counter
        tick();
        load_b();
        for (int c = 0; c < 20; c++) tick();
        clr_b();
        #2 chk("sat_cnt15", 32'(bus_b.stall_cycles), 32'd15);
        for (int c = 0; c < 4; c++) tick();
        chk("sat_hold15", 32'(bus_b.stall_cycles), 32'd15);
        chk("sat_idle", 32'(bus_b.stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
